gemm_result_collector: RTL

Downstream companion to the fixed-weights GEMM systolic array. The GEMM consumes one activation row per cycle, cannot stall, and produces each result exactly 2*SA_SIZE cycles after its input. This block tags which input cycles carried real rows, captures the matching GEMM outputs into a FIFO, and presents them to the consumer over valid/ready. Credit-based flow control toward the row source guarantees FIFO room for every in-flight row.

---
 rtl/gemm_result_collector_pkg.sv | 19 +
 rtl/gemm_result_fifo.sv | 81 ++++++++
 rtl/gemm_result_collector.sv | 115 +++++++++++
 3 files changed

// File: rtl/gemm_result_collector_pkg.sv
// -----------------------------------------------------------------------------
// gemm_result_collector_pkg
//   Shared constants and helpers for the GEMM result collection path.
//   - SEQ_WIDTH    : width of the per-result sequence number
//   - gemm_latency : input-to-output latency of the fixed-weights systolic array
//   - seq_t        : sequence number type
// -----------------------------------------------------------------------------
package gemm_result_collector_pkg;

    localparam int SEQ_WIDTH = 16;

    typedef logic [SEQ_WIDTH-1:0] seq_t;

    // A row entering the array at edge k leaves it at edge k + 2*SA_SIZE.
    function automatic int gemm_latency(input int sa_size);
        return 2 * sa_size;
    endfunction

endpackage

// File: rtl/gemm_result_fifo.sv
// -----------------------------------------------------------------------------
// gemm_result_fifo
//   Circular-buffer FIFO with first-word-fall-through read.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     push, wdata     : write request and data
//     pop             : read request (ignored while empty)
//     rdata           : head entry, zero while empty
//     count           : number of stored entries (0..DEPTH)
//     full, empty     : occupancy flags
//     overflow        : one-cycle pulse when a push is dropped because full
// -----------------------------------------------------------------------------
module gemm_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        full     = 1'b0;
        empty    = 1'b0;
        do_pop   = 1'b0;
        do_push  = 1'b0;
        overflow = 1'b0;
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot the push needs.
        do_push  = push && (!full || do_pop);
        overflow = push && full && !do_pop;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count, and the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/gemm_result_collector.sv
// -----------------------------------------------------------------------------
// gemm_result_collector
//   Tags real rows entering the non-stallable GEMM, captures the matching
//   outputs L = 2*SA_SIZE edges later into a FIFO together with a sequence
//   number, and presents them over valid/ready. Credits toward the row source
//   count both stored and in-flight rows, so a capture always finds room.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     src_valid/src_ready : row source handshake (src_ready = credit available)
//     gemm_out            : GEMM activation_outputs, SA_SIZE elements
//     gemm_output_valid   : GEMM output_valid
//     res_data/res_seq    : head-of-FIFO row and its sequence number
//     res_valid/res_ready : consumer handshake
//     err_overflow        : sticky, capture dropped with FIFO full
//     err_early           : sticky, tagged capture with gemm_output_valid low
// -----------------------------------------------------------------------------
module gemm_result_collector
    import gemm_result_collector_pkg::*;
#(
    parameter int SA_SIZE                = 8,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int FIFO_DEPTH             = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      src_valid,
    output logic                                      src_ready,
    input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] gemm_out,
    input  logic                                      gemm_output_valid,
    output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] res_data,
    output logic [SEQ_WIDTH-1:0]                      res_seq,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic                                      err_overflow,
    output logic                                      err_early
);

    localparam int L     = gemm_latency(SA_SIZE);
    localparam int ROW_W = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
    localparam int INF_W = $clog2(L + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + L + 1);

    typedef struct packed {
        logic [ROW_W-1:0] data;
        seq_t             seq;
    } result_t;

    logic [L-1:0]     tag_line;
    logic [INF_W-1:0] inflight;
    seq_t             seq_cnt;
    logic             accept;
    logic             capture;
    logic             pop;

    result_t          wr_entry;
    result_t          rd_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_overflow;

    assign accept   = src_valid && src_ready;
    // The tap at L-1 holds the accept from L-1 edges ago; the capture itself
    // happens on the next edge, exactly L edges after the accept.
    assign capture  = tag_line[L-1];
    assign pop      = res_valid && res_ready;
    assign wr_entry = '{data: gemm_out, seq: seq_cnt};

    // Credit check uses registered state only, so there is no combinational
    // path from src_valid or res_ready to src_ready.
    assign src_ready = !fifo_full &&
                       ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_line     <= '0;
            inflight     <= '0;
            seq_cnt      <= '0;
            err_overflow <= 1'b0;
            err_early    <= 1'b0;
        end else begin
            tag_line <= {tag_line[L-2:0], accept};
            if (capture) seq_cnt <= seq_cnt + seq_t'(1);
            case ({accept, capture})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase
            if (fifo_overflow)                  err_overflow <= 1'b1;
            if (capture && !gemm_output_valid)  err_early    <= 1'b1;
        end
    end

    gemm_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (capture),
        .wdata    (wr_entry),
        .pop      (pop),
        .rdata    (rd_entry),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    assign res_valid = !fifo_empty;
    assign res_data  = rd_entry.data;
    assign res_seq   = rd_entry.seq;

endmodule
